edge_generator: RTL
===================

# edge_generator

Programmable edge/pulse stimulus source; the transmit-side counterpart of `edge_counter`. On a start request it drives a square-wave pulse train on `signal` with a programmed pulse count, high time and low time. It keeps running tallies of the rising and falling edges it has emitted, so a paired counter can be checked directly against `posedge_sent`/`negedge_sent`. It sits beside `edge_counter` in self-checking benches and on-chip loopback test paths.

## Interface

- `CNT_W`, default 32: width of the pulse-count input and of the edge tallies.
- `DUR_W`, default 16: width of the high/low duration inputs, in clock cycles.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a new pulse train; accepted only when `busy`=0.
- `abort` in 1: synchronous cancel of the current train.
- `num_pulses` in CNT_W: pulses to emit; captured when `start` is accepted.
- `high_cycles` in DUR_W: high time per pulse; captured when `start` is accepted; 0 is treated as 1.
- `low_cycles` in DUR_W: low time per pulse; captured when `start` is accepted; 0 is treated as 1.
- `signal` out 1: generated waveform, registered.
- `busy` out 1: a train is in progress.
- `done` out 1: one-cycle pulse when a train completes normally.
- `posedge_sent` out CNT_W: cumulative count of 0→1 transitions driven on `signal`.
- `negedge_sent` out CNT_W: cumulative count of 1→0 transitions driven on `signal`.

## Operation

- Reset (`reset_n`=0, asynchronous): all outputs go to 0 and the FSM goes to IDLE.
- FSM states: IDLE, HIGH, LOW.
- IDLE, `start`=1, `abort`=0, `num_pulses`≠0:
  - capture all three parameters;
  - `signal`←1, `posedge_sent`++, `busy`←1;
  - go to HIGH with the duration counter loaded.
- IDLE, `start`=1, `num_pulses`=0: no edges; `done`←1 for one cycle; stay in IDLE.
- HIGH: after H cycles at 1, `signal`←0, `negedge_sent`++, go to LOW.
- LOW, after L cycles at 0:
  - if pulses remain: `signal`←1, `posedge_sent`++, go to HIGH;
  - otherwise: go to IDLE, `busy`←0, `done`←1 for one cycle.
- The final low phase is part of the train. A train of N pulses therefore spans exactly N·(H+L) cycles.
- `start` while `busy`=1 is ignored; the captured parameters are not disturbed.
- `abort`=1 while `busy`=1:
  - next edge: `signal`←0; `negedge_sent`++ only if `signal` was 1;
  - `busy`←0, FSM to IDLE, `done` stays 0.
- `abort` and `start` in the same IDLE cycle: `abort` wins and `start` is dropped.
- Tallies are not cleared by `start`. They accumulate across trains and wrap modulo 2^CNT_W. Only `reset_n` clears them.
- Invariant: `posedge_sent` − `negedge_sent` equals `signal` (0 or 1) at every cycle.

## Timing

- `start` sampled at edge T: `signal`, `busy` and `posedge_sent` update at edge T (visible in cycle T+1).
- `signal` is high for edges T … T+H−1, and low from edge T+H for L cycles.
- The k-th rising edge (k from 0) occurs at edge T+k·(H+L). The k-th falling edge occurs at edge T+k·(H+L)+H.
- `done`=1 and `busy`=0 are set at edge T+N·(H+L). `done` is high for exactly one cycle.
- A new `start` is accepted at edge T+N·(H+L)+1 or later. The minimum gap between trains is 1 cycle.
- `num_pulses`=0: `done` is set at edge T; `busy` stays 0.
- All outputs are registered; there are no combinational input→output paths.

## Test plan

1. Reset: hold `reset_n`=0 mid-clock.
   - Required: all outputs 0 immediately.
   - Release, then idle 10 cycles: outputs remain 0.
2. `start` with N=3, H=2, L=3.
   - Required: `signal` pattern 11000 repeated 3 times; `busy`=1 for 15 cycles.
   - Required: `done` pulses once at edge T+15; counts 3/3.
   - Paired `edge_counter` reports 3/3.
3. `start` with N=0.
   - Required: `done` pulses at edge T; `signal` never toggles; counts unchanged; `busy` stays 0.
4. `start` with N=4, H=0, L=0.
   - Required: treated as 1/1, giving a period-2 square wave; `done` at edge T+8; counts 4/4.
5. Run the case-2 train, pulsing `start` twice mid-train; then start a second N=3 train after `done`.
   - Required: the mid-train pulses are ignored.
   - Required: final counts 6/6 (cumulative, not reset by `start`).
6. `start` with N=5, H=4, L=4; assert `abort` at edge T+9 (second pulse high).
   - Required at the next edge: `signal`=0, counts 2/2, `busy`=0, `done` never asserted.
   - Repeat, asserting `reset_n`=0 mid-train: all outputs 0 asynchronously.

Source files
------------

// File: rtl/edge_generator.sv
// Programmable pulse-train source: emits N pulses of H high / L low cycles on a
// registered output and keeps cumulative rising/falling edge tallies.
module edge_generator #(
    parameter int CNT_W = 32,
    parameter int DUR_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [DUR_W-1:0] high_cycles,
    input  logic [DUR_W-1:0] low_cycles,
    output logic             signal,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] posedge_sent,
    output logic [CNT_W-1:0] negedge_sent
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t           state_r,       state_s;
    logic [DUR_W-1:0] dur_cnt_r,     dur_cnt_s;
    logic [DUR_W-1:0] high_m1_r,     high_m1_s;
    logic [DUR_W-1:0] low_m1_r,      low_m1_s;
    logic [CNT_W-1:0] pulses_left_r, pulses_left_s;
    logic [CNT_W-1:0] pos_r,         pos_s;
    logic [CNT_W-1:0] neg_r,         neg_s;
    logic             signal_r,      signal_s;
    logic             busy_r,        busy_s;
    logic             done_r,        done_s;

    // Phase length minus one; a programmed 0 behaves as a 1-cycle phase.
    function automatic logic [DUR_W-1:0] dur_m1(input logic [DUR_W-1:0] d);
        logic [DUR_W-1:0] r;
        if (d == '0) begin
            r = '0;
        end else begin
            r = d - DUR_ONE;
        end
        return r;
    endfunction

    // Next-state, waveform and tally logic.
    always_comb begin
        state_s       = state_r;
        dur_cnt_s     = dur_cnt_r;
        high_m1_s     = high_m1_r;
        low_m1_s      = low_m1_r;
        pulses_left_s = pulses_left_r;
        pos_s         = pos_r;
        neg_s         = neg_r;
        signal_s      = signal_r;
        busy_s        = busy_r;
        done_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (start && (num_pulses == '0)) begin
                    done_s = 1'b1;
                end else if (start) begin
                    high_m1_s     = dur_m1(high_cycles);
                    low_m1_s      = dur_m1(low_cycles);
                    dur_cnt_s     = dur_m1(high_cycles);
                    pulses_left_s = num_pulses - CNT_ONE;
                    signal_s      = 1'b1;
                    busy_s        = 1'b1;
                    pos_s         = pos_r + CNT_ONE;
                    state_s       = ST_HIGH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HIGH, ST_LOW: begin
                if (abort) begin
                    // Only a level that is actually high produces a falling edge
                    if (signal_r) begin
                        neg_s = neg_r + CNT_ONE;
                    end else begin
                        neg_s = neg_r;
                    end
                    signal_s = 1'b0;
                    busy_s   = 1'b0;
                    state_s  = ST_IDLE;
                end else if (dur_cnt_r != '0) begin
                    dur_cnt_s = dur_cnt_r - DUR_ONE;
                end else if (state_r == ST_HIGH) begin
                    signal_s  = 1'b0;
                    neg_s     = neg_r + CNT_ONE;
                    dur_cnt_s = low_m1_r;
                    state_s   = ST_LOW;
                end else if (pulses_left_r != '0) begin
                    pulses_left_s = pulses_left_r - CNT_ONE;
                    signal_s      = 1'b1;
                    pos_s         = pos_r + CNT_ONE;
                    dur_cnt_s     = high_m1_r;
                    state_s       = ST_HIGH;
                end else begin
                    // Final low phase has elapsed: the train is complete
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end
            end
            default: begin
                signal_s = 1'b0;
                busy_s   = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            dur_cnt_r     <= '0;
            high_m1_r     <= '0;
            low_m1_r      <= '0;
            pulses_left_r <= '0;
            pos_r         <= '0;
            neg_r         <= '0;
            signal_r      <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            dur_cnt_r     <= dur_cnt_s;
            high_m1_r     <= high_m1_s;
            low_m1_r      <= low_m1_s;
            pulses_left_r <= pulses_left_s;
            pos_r         <= pos_s;
            neg_r         <= neg_s;
            signal_r      <= signal_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
        end
    end

    assign signal       = signal_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign posedge_sent = pos_r;
    assign negedge_sent = neg_r;

    edge_generator_checker #(.CNT_W(CNT_W)) u_checker (
        .clk          (clk),
        .reset_n      (reset_n),
        .signal       (signal_r),
        .busy         (busy_r),
        .done         (done_r),
        .posedge_sent (pos_r),
        .negedge_sent (neg_r)
    );

endmodule

// Structural properties of the generator outputs.
module edge_generator_checker #(
    parameter int CNT_W = 32
) (
    input logic             clk,
    input logic             reset_n,
    input logic             signal,
    input logic             busy,
    input logic             done,
    input logic [CNT_W-1:0] posedge_sent,
    input logic [CNT_W-1:0] negedge_sent
);

    // Tallies differ by exactly the current output level.
    tally_balance_a : assert property (@(posedge clk) disable iff (!reset_n)
        (CNT_W'(posedge_sent - negedge_sent) == CNT_W'(signal)));

    done_idle_a : assert property (@(posedge clk) disable iff (!reset_n)
        done |-> !busy);

endmodule
